// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// rst_sequencer : synchronizes lock/button, debounces the button and releases
//                 peripheral then core resets after a request-free hold period.
// Rev 1.0
// ============================================================================
module rst_sequencer #(
   parameter int SyncStages     = 2,
   parameter int DebounceCycles = 16,
   parameter int HoldCycles     = 32,
   parameter int StageGap       = 8
) (
   input  logic       clk_sys,
   input  logic       rst_sys_n,
   input  logic       locked_i,
   input  logic       rst_btn_ni,
   input  logic       sw_rst_req_i,
   output logic       rst_periph_no,
   output logic       rst_core_no,
   output logic       rst_done_o,
   output logic [2:0] rst_cause_o,
   output logic [7:0] rst_count_o
);

   localparam int c_HOLD_W = $clog2(HoldCycles + 1);
   localparam int c_GAP_W  = $clog2(StageGap + 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_END = c_HOLD_W'(HoldCycles);
   localparam logic [c_GAP_W-1:0]  c_GAP_END  = c_GAP_W'(StageGap);
   localparam logic [7:0]          c_DBNC_END = 8'(DebounceCycles - 1);

   typedef enum logic [1:0] {
      S_HOLD   = 2'd0,
      S_PERIPH = 2'd1,
      S_CORE   = 2'd2,
      S_RUN    = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SyncStages-1:0] r_lock_sync;
   logic [SyncStages-1:0] r_btn_sync;
   logic [7:0]            r_dbnc_cnt;
   logic [c_HOLD_W-1:0]   r_hold_cnt;
   logic [c_HOLD_W-1:0]   w_hold_cnt_nxt;
   logic [c_GAP_W-1:0]    r_gap_cnt;
   logic [c_GAP_W-1:0]    w_gap_cnt_nxt;
   logic                  w_lock_req;
   logic                  w_btn_low;
   logic                  w_btn_req;
   logic                  w_sw_req;
   logic                  w_any_req;
   logic                  w_abort;
   logic                  w_periph_nxt;
   logic                  w_core_nxt;
   logic                  w_done_nxt;
   logic [2:0]            w_cause_nxt;
   logic [7:0]            w_count_nxt;

   // Synchronizers reset to 0, so lock reads as lost until the chain fills.
   always_ff @(posedge clk_sys) begin
      if (!rst_sys_n) begin
         r_lock_sync <= '0;
         r_btn_sync  <= '0;
      end else begin
         r_lock_sync <= {r_lock_sync[SyncStages-2:0], locked_i};
         r_btn_sync  <= {r_btn_sync[SyncStages-2:0], rst_btn_ni};
      end
   end

   assign w_lock_req = ~r_lock_sync[SyncStages-1];
   assign w_btn_low  = ~r_btn_sync[SyncStages-1];

   always_ff @(posedge clk_sys) begin
      if (!rst_sys_n) begin
         r_dbnc_cnt <= '0;
      end else if (!w_btn_low) begin
         r_dbnc_cnt <= '0;
      end else if (r_dbnc_cnt != c_DBNC_END) begin
         r_dbnc_cnt <= r_dbnc_cnt + 8'd1;
      end
   end

   // Counter holds the number of earlier low readings; this one is the last needed.
   assign w_btn_req = w_btn_low && (r_dbnc_cnt == c_DBNC_END);
   assign w_sw_req  = sw_rst_req_i && (r_state == S_RUN);
   assign w_any_req = w_lock_req || w_btn_req || w_sw_req;

   always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = '0;
      w_gap_cnt_nxt  = '0;
      w_abort        = 1'b0;
      w_cause_nxt    = rst_cause_o;
      w_count_nxt    = rst_count_o;

      case (r_state)
         S_HOLD: begin
            if (w_any_req) begin
               w_state_nxt = S_HOLD;
            end else if (r_hold_cnt == c_HOLD_END) begin
               w_state_nxt = S_PERIPH;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + c_HOLD_W'(1);
            end
         end
         S_PERIPH: begin
            if (w_any_req) begin
               w_state_nxt = S_HOLD;
            end else if (r_gap_cnt == c_GAP_END) begin
               w_state_nxt = S_CORE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + c_GAP_W'(1);
            end
         end
         S_CORE: begin
            w_state_nxt = w_any_req ? S_HOLD : S_RUN;
         end
         S_RUN: begin
            w_state_nxt = w_any_req ? S_HOLD : S_RUN;
         end
         default: begin
            w_state_nxt = S_HOLD;
         end
      endcase

      w_abort = (r_state != S_HOLD) && w_any_req;
      if (w_abort) begin
         if (w_lock_req) begin
            w_cause_nxt = 3'b001;
         end else if (w_btn_req) begin
            w_cause_nxt = 3'b010;
         end else begin
            w_cause_nxt = 3'b100;
         end
         if (rst_count_o != 8'hFF) begin
            w_count_nxt = rst_count_o + 8'd1;
         end
      end

      // Outputs are registered from the next state so they switch on the same edge.
      w_periph_nxt = (w_state_nxt != S_HOLD);
      w_core_nxt   = (w_state_nxt == S_CORE) || (w_state_nxt == S_RUN);
      w_done_nxt   = (w_state_nxt == S_RUN);
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_sys_n) begin
         r_state       <= S_HOLD;
         r_hold_cnt    <= '0;
         r_gap_cnt     <= '0;
         rst_periph_no <= 1'b0;
         rst_core_no   <= 1'b0;
         rst_done_o    <= 1'b0;
         rst_cause_o   <= 3'b000;
         rst_count_o   <= 8'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_hold_cnt    <= w_hold_cnt_nxt;
         r_gap_cnt     <= w_gap_cnt_nxt;
         rst_periph_no <= w_periph_nxt;
         rst_core_no   <= w_core_nxt;
         rst_done_o    <= w_done_nxt;
         rst_cause_o   <= w_cause_nxt;
         rst_count_o   <= w_count_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rst_sequencer : scoreboard bench; expected output vectors are queued with
//                    their due edge when stimulus is driven.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rst_sequencer;

   localparam int SS = 2;
   localparam int DB = 16;
   localparam int HC = 32;
   localparam int SG = 8;

   logic       clk_sys      = 1'b0;
   logic       rst_sys_n    = 1'b0;
   logic       locked_i     = 1'b1;
   logic       rst_btn_ni   = 1'b1;
   logic       sw_rst_req_i = 1'b0;
   logic       rst_periph_no;
   logic       rst_core_no;
   logic       rst_done_o;
   logic [2:0] rst_cause_o;
   logic [7:0] rst_count_o;

   always #5 clk_sys = ~clk_sys;

   rst_sequencer #(
      .SyncStages    (SS),
      .DebounceCycles(DB),
      .HoldCycles    (HC),
      .StageGap      (SG)
   ) dut (
      .clk_sys      (clk_sys),
      .rst_sys_n    (rst_sys_n),
      .locked_i     (locked_i),
      .rst_btn_ni   (rst_btn_ni),
      .sw_rst_req_i (sw_rst_req_i),
      .rst_periph_no(rst_periph_no),
      .rst_core_no  (rst_core_no),
      .rst_done_o   (rst_done_o),
      .rst_cause_o  (rst_cause_o),
      .rst_count_o  (rst_count_o)
   );

   typedef struct {
      int          cyc;
      logic [13:0] vec;
   } exp_t;

   exp_t        sb_q[$];
   string       sb_tag[$];
   int          checks   = 0;
   int          failures = 0;
   int          edge_n   = -1;
   int          m_count  = 0;
   logic [2:0]  m_cause  = 3'b000;
   logic [13:0] m_vec    = '0;
   bit          mon_en   = 1'b0;

   wire [13:0] dut_vec = {rst_periph_no, rst_core_no, rst_done_o, rst_cause_o, rst_count_o};

   always @(posedge clk_sys) edge_n <= edge_n + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
      end
   endtask

   function automatic void expect_at(input string tag, input int cyc, input logic p,
                                     input logic c, input logic d);
      exp_t e;
      e.cyc = cyc;
      e.vec = {p, c, d, m_cause, 8'(m_count)};
      sb_q.push_back(e);
      sb_tag.push_back(tag);
   endfunction

   function automatic void expect_drop(input string tag, input int cyc, input logic [2:0] cause);
      if (m_count < 255) m_count++;
      m_cause = cause;
      expect_at(tag, cyc, 1'b0, 1'b0, 1'b0);
   endfunction

   // t is the first request-free HOLD edge.
   function automatic void expect_release(input string tag, input int t);
      expect_at({tag, "_periph"}, t + HC,          1'b1, 1'b0, 1'b0);
      expect_at({tag, "_core"},   t + HC + SG + 1, 1'b1, 1'b1, 1'b0);
      expect_at({tag, "_done"},   t + HC + SG + 2, 1'b1, 1'b1, 1'b1);
   endfunction

   task automatic wait_edge(input int n);
      while (edge_n < n) @(negedge clk_sys);
   endtask

   // Every cycle the DUT must hold the last expected vector, switching only on due edges.
   always @(negedge clk_sys) begin
      string tag;
      exp_t  e;
      if (mon_en) begin
         while (sb_q.size() > 0 && sb_q[0].cyc < edge_n) begin
            e   = sb_q.pop_front();
            tag = sb_tag.pop_front();
            check_val({"late_", tag}, 32'(edge_n), 32'(e.cyc));
         end
         tag = "steady";
         if (sb_q.size() > 0 && sb_q[0].cyc == edge_n) begin
            e     = sb_q.pop_front();
            tag   = sb_tag.pop_front();
            m_vec = e.vec;
         end
         check_val(tag, 32'(dut_vec), 32'(m_vec));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, edge %0d", edge_n);
      $fatal(1);
   end

   initial begin
      int e;
      int e2;

      // Power-on reset and nominal sequence
      repeat (3) @(negedge clk_sys);
      check_val("reset_state", 32'(dut_vec), 32'd0);
      mon_en    = 1'b1;
      e         = edge_n;
      rst_sys_n = 1'b1;
      expect_release("por", e + 3);
      wait_edge(e + 3 + HC + SG + 2 + 3);

      // Short button press is filtered
      rst_btn_ni = 1'b0;
      repeat (10) @(negedge clk_sys);
      rst_btn_ni = 1'b1;
      repeat (30) @(negedge clk_sys);

      // Long button press
      e          = edge_n;
      rst_btn_ni = 1'b0;
      expect_drop("btn_drop", e + SS + DB, 3'b010);
      repeat (40) @(negedge clk_sys);
      e2         = edge_n;
      rst_btn_ni = 1'b1;
      expect_release("btn", e2 + 3);
      wait_edge(e2 + 3 + HC + SG + 2 + 3);

      // Lock and button together: lock has priority
      e          = edge_n;
      locked_i   = 1'b0;
      rst_btn_ni = 1'b0;
      expect_drop("lockbtn_drop", e + 3, 3'b001);
      repeat (40) @(negedge clk_sys);
      e2         = edge_n;
      locked_i   = 1'b1;
      rst_btn_ni = 1'b1;
      expect_release("lockbtn", e2 + 3);
      wait_edge(e2 + 3 + HC + SG + 2 + 3);

      // Software request in RUN, then a pulse during PERIPH that must be ignored
      e            = edge_n;
      sw_rst_req_i = 1'b1;
      expect_drop("sw_drop", e + 1, 3'b100);
      @(negedge clk_sys);
      sw_rst_req_i = 1'b0;
      expect_release("sw", e + 2);
      wait_edge(e + 2 + HC + 2);
      sw_rst_req_i = 1'b1;
      @(negedge clk_sys);
      sw_rst_req_i = 1'b0;
      wait_edge(e + 2 + HC + SG + 2 + 3);

      // Repeated lock loss drives the event counter into saturation
      for (int i = 0; i < 300; i++) begin
         e        = edge_n;
         locked_i = 1'b0;
         expect_drop("sat_drop", e + 3, 3'b001);
         @(negedge clk_sys);
         locked_i = 1'b1;
         expect_at("sat_periph", e + 4 + HC, 1'b1, 1'b0, 1'b0);
         wait_edge(e + 4 + HC);
      end
      check_val("count_sat", 32'(rst_count_o), 32'd255);

      // Block reset while in PERIPH aborts and restarts the sequence
      e         = edge_n;
      rst_sys_n = 1'b0;
      m_count   = 0;
      m_cause   = 3'b000;
      expect_at("rst_abort", e + 1, 1'b0, 1'b0, 1'b0);
      @(negedge clk_sys);
      rst_sys_n = 1'b1;
      expect_release("rerun", e + 4);
      wait_edge(e + 4 + HC + SG + 2 + 5);

      check_val("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
